// File: rtl/lmc_pkg.sv
// Shared constants, function codes and FSM state type for the LMC1992 microwire responder.
package lmc_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_e;

  localparam int FRAME_BITS = 11;

  localparam logic [2:0] FN_MIXER  = 3'd0;
  localparam logic [2:0] FN_BASS   = 3'd1;
  localparam logic [2:0] FN_TREBLE = 3'd2;
  localparam logic [2:0] FN_MASTER = 3'd3;
  localparam logic [2:0] FN_RIGHT  = 3'd4;
  localparam logic [2:0] FN_LEFT   = 3'd5;

  localparam logic [5:0] MAX_MASTER   = 6'd40;
  localparam logic [4:0] MAX_LR       = 5'd20;
  localparam logic [3:0] MAX_TONE     = 4'd12;
  localparam logic [1:0] MIX_RESERVED = 2'd3;

  localparam logic [5:0] RST_MASTER = 6'd40;
  localparam logic [4:0] RST_LR     = 5'd20;
  localparam logic [3:0] RST_TONE   = 4'd6;
  localparam logic [1:0] RST_MIXER  = 2'd1;

endpackage

// File: rtl/lmc_frame_rx.sv
// Microwire frame receiver: edge detect, 11-bit shifter, bit counter, idle timeout and frame FSM.
module lmc_frame_rx
  import lmc_pkg::*;
#(
  parameter int TIMEOUT = 512
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic        mw_clk_i,
  input  logic        mw_data_i,
  input  logic        mw_done_i,
  output logic [10:0] frame_o,
  output logic        frame_ok_o,
  output logic        frame_short_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          mw_clk_q, mw_done_q;
  state_e        state_q, state_d;
  logic [10:0]   shift_q, shift_d;
  logic [4:0]    count_q, count_d;
  logic [TW-1:0] tout_q, tout_d;
  logic          clk_rise, done_rise;

  assign clk_rise  = mw_clk_i & ~mw_clk_q;
  assign done_rise = mw_done_i & ~mw_done_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    tout_d  = tout_q;
    case (state_q)
      IDLE: begin
        tout_d = '0;
        if (clk_rise) begin
          shift_d = {shift_q[9:0], mw_data_i};
          count_d = 5'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (clk_rise) begin
          shift_d = {shift_q[9:0], mw_data_i};
          count_d = (count_q == 5'd31) ? 5'd31 : count_q + 5'd1;
          tout_d  = '0;
        end
        // A coincident bit has already been shifted above, so the frame includes it.
        if (done_rise) begin
          state_d = DECODE;
          tout_d  = '0;
        end else if (!clk_rise) begin
          if (tout_q == TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            count_d = '0;
            tout_d  = '0;
          end else begin
            tout_d = tout_q + 1'b1;
          end
        end
      end
      DECODE: begin
        state_d = IDLE;
        count_d = '0;
        tout_d  = '0;
        if (clk_rise) begin
          shift_d = {shift_q[9:0], mw_data_i};
          count_d = 5'd1;
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      mw_clk_q  <= 1'b0;
      mw_done_q <= 1'b0;
      state_q   <= IDLE;
      shift_q   <= '0;
      count_q   <= '0;
      tout_q    <= '0;
    end else begin
      mw_clk_q  <= mw_clk_i;
      mw_done_q <= mw_done_i;
      state_q   <= state_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      tout_q    <= tout_d;
    end
  end

  assign frame_o       = shift_q;
  assign frame_ok_o    = (state_q == DECODE) && (count_q >= 5'(FRAME_BITS));
  assign frame_short_o = (state_q == DECODE) && (count_q <  5'(FRAME_BITS));

endmodule

// File: rtl/lmc_microwire_rx.sv
// LMC1992 responder top: validates and decodes received frames into clamped mixer settings.
module lmc_microwire_rx
  import lmc_pkg::*;
#(
  parameter logic [1:0] DEV_ADDR = 2'b10,
  parameter int         TIMEOUT  = 512
) (
  input  logic       clk32,
  input  logic       reset,
  input  logic       mw_clk,
  input  logic       mw_data,
  input  logic       mw_done,
  output logic [5:0] master_vol,
  output logic [4:0] left_vol,
  output logic [4:0] right_vol,
  output logic [3:0] bass,
  output logic [3:0] treble,
  output logic [1:0] mixer,
  output logic       cmd_valid,
  output logic       cmd_err
);

  logic [10:0] frame;
  logic        frame_ok, frame_short;

  lmc_frame_rx #(.TIMEOUT(TIMEOUT)) u_frame_rx (
    .clk32         (clk32),
    .reset         (reset),
    .mw_clk_i      (mw_clk),
    .mw_data_i     (mw_data),
    .mw_done_i     (mw_done),
    .frame_o       (frame),
    .frame_ok_o    (frame_ok),
    .frame_short_o (frame_short)
  );

  logic [5:0] master_q, master_d;
  logic [4:0] left_q, left_d, right_q, right_d;
  logic [3:0] bass_q, bass_d, treble_q, treble_d;
  logic [1:0] mixer_q, mixer_d;
  logic       valid_q, valid_d, err_q, err_d;
  logic       accept;
  logic [5:0] d;

  assign d = frame[5:0];

  always_comb begin
    master_d = master_q;
    left_d   = left_q;
    right_d  = right_q;
    bass_d   = bass_q;
    treble_d = treble_q;
    mixer_d  = mixer_q;
    accept   = 1'b0;
    if (frame_ok && frame[10:9] == DEV_ADDR) begin
      case (frame[8:6])
        FN_MIXER: if (d[1:0] != MIX_RESERVED) begin
          accept  = 1'b1;
          mixer_d = d[1:0];
        end
        FN_BASS:   begin accept = 1'b1; bass_d   = (d[3:0] > MAX_TONE)   ? MAX_TONE   : d[3:0]; end
        FN_TREBLE: begin accept = 1'b1; treble_d = (d[3:0] > MAX_TONE)   ? MAX_TONE   : d[3:0]; end
        FN_MASTER: begin accept = 1'b1; master_d = (d > MAX_MASTER)      ? MAX_MASTER : d;      end
        FN_RIGHT:  begin accept = 1'b1; right_d  = (d[4:0] > MAX_LR)     ? MAX_LR     : d[4:0]; end
        FN_LEFT:   begin accept = 1'b1; left_d   = (d[4:0] > MAX_LR)     ? MAX_LR     : d[4:0]; end
        default:   accept = 1'b0;
      endcase
    end
    valid_d = accept;
    err_d   = frame_short | (frame_ok & ~accept);
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      master_q <= RST_MASTER;
      left_q   <= RST_LR;
      right_q  <= RST_LR;
      bass_q   <= RST_TONE;
      treble_q <= RST_TONE;
      mixer_q  <= RST_MIXER;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      master_q <= master_d;
      left_q   <= left_d;
      right_q  <= right_d;
      bass_q   <= bass_d;
      treble_q <= treble_d;
      mixer_q  <= mixer_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign master_vol = master_q;
  assign left_vol   = left_q;
  assign right_vol  = right_q;
  assign bass       = bass_q;
  assign treble     = treble_q;
  assign mixer      = mixer_q;
  assign cmd_valid  = valid_q;
  assign cmd_err    = err_q;

endmodule

// File: tb/tb_lmc_microwire_rx.sv
// Scoreboard bench for lmc_microwire_rx: a behavioural microwire master and an independent settings model.
module tb_lmc_microwire_rx;

  localparam int TIMEOUT = 512;

  logic       clk32 = 1'b0;
  logic       reset, mw_clk, mw_data, mw_done;
  logic [5:0] master_vol;
  logic [4:0] left_vol, right_vol;
  logic [3:0] bass, treble;
  logic [1:0] mixer;
  logic       cmd_valid, cmd_err;

  always #5 clk32 = ~clk32;

  lmc_microwire_rx #(.DEV_ADDR(2'b10), .TIMEOUT(TIMEOUT)) dut (
    .clk32      (clk32),
    .reset      (reset),
    .mw_clk     (mw_clk),
    .mw_data    (mw_data),
    .mw_done    (mw_done),
    .master_vol (master_vol),
    .left_vol   (left_vol),
    .right_vol  (right_vol),
    .bass       (bass),
    .treble     (treble),
    .mixer      (mixer),
    .cmd_valid  (cmd_valid),
    .cmd_err    (cmd_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // kind is {cmd_valid, cmd_err}; set is {master,left,right,bass,treble,mixer}
  typedef struct packed {
    logic [1:0]  kind;
    logic [25:0] set;
  } exp_t;
  exp_t sb_q[$];

  logic [5:0] m_master;
  logic [4:0] m_left, m_right;
  logic [3:0] m_bass, m_treble;
  logic [1:0] m_mixer;
  logic [25:0] dut_set;
  assign dut_set = {master_vol, left_vol, right_vol, bass, treble, mixer};

  task automatic model_reset();
    m_master = 6'd40; m_left = 5'd20; m_right = 5'd20;
    m_bass = 4'd6; m_treble = 4'd6; m_mixer = 2'd1;
  endtask

  task automatic push_exp(input logic [31:0] bits, input int n);
    logic [10:0] w;
    logic [5:0]  dv;
    bit          ok;
    w  = bits[10:0];
    dv = w[5:0];
    ok = (n >= 11) && (w[10:9] == 2'b10);
    if (ok) begin
      case (w[8:6])
        3'd0: if (dv[1:0] == 2'd3) ok = 0; else m_mixer = dv[1:0];
        3'd1: m_bass   = (dv[3:0] > 4'd12) ? 4'd12 : dv[3:0];
        3'd2: m_treble = (dv[3:0] > 4'd12) ? 4'd12 : dv[3:0];
        3'd3: m_master = (dv > 6'd40) ? 6'd40 : dv;
        3'd4: m_right  = (dv[4:0] > 5'd20) ? 5'd20 : dv[4:0];
        3'd5: m_left   = (dv[4:0] > 5'd20) ? 5'd20 : dv[4:0];
        default: ok = 0;
      endcase
    end
    sb_q.push_back('{kind: ok ? 2'b10 : 2'b01,
                     set: {m_master, m_left, m_right, m_bass, m_treble, m_mixer}});
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk32);
      if (!reset && (cmd_valid || cmd_err)) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_pulse", 32'({cmd_valid, cmd_err}), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("pulse_kind", 32'({cmd_valid, cmd_err}), 32'(e.kind));
          check_eq("settings", 32'(dut_set), 32'(e.set));
          $display("frame: valid=%0d err=%0d master=%0d left=%0d right=%0d bass=%0d treble=%0d mixer=%0d",
                   cmd_valid, cmd_err, master_vol, left_vol, right_vol, bass, treble, mixer);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk32);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input bit coincident);
    for (int i = n - 1; i >= 0; i--) begin
      tick(1);
      mw_data = bits[i];
      mw_clk  = 1'b0;
      tick(2);
      mw_clk = 1'b1;
      if (coincident && i == 0) mw_done = 1'b1;
      tick(2);
    end
    mw_clk = 1'b0;
  endtask

  // Raises mw_done (unless already high) and checks the pulse lands exactly two clocks later.
  task automatic end_frame(input bit pulse_exp, input bit already_high);
    tick(2);
    if (!already_high) begin
      mw_done = 1'b1;
      tick(1);
      check_eq("early_pulse", 32'(cmd_valid | cmd_err), 32'd0);
      tick(1);
      check_eq("pulse_latency", 32'(cmd_valid | cmd_err), 32'(pulse_exp));
    end else begin
      tick(2);
    end
    mw_done = 1'b0;
    tick(2);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) tick(1);
    if (sb_q.size() != 0) begin
      check_eq("pulse_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic frame(input logic [31:0] bits, input int n);
    push_exp(bits, n);
    send_bits(bits, n, 1'b0);
    end_frame(1'b1, 1'b0);
    drain();
  endtask

  task automatic check_defaults(input string tag);
    check_eq({tag, "_master"}, 32'(master_vol), 32'd40);
    check_eq({tag, "_left"},   32'(left_vol),   32'd20);
    check_eq({tag, "_right"},  32'(right_vol),  32'd20);
    check_eq({tag, "_bass"},   32'(bass),       32'd6);
    check_eq({tag, "_treble"}, 32'(treble),     32'd6);
    check_eq({tag, "_mixer"},  32'(mixer),      32'd1);
    check_eq({tag, "_pulses"}, 32'({cmd_valid, cmd_err}), 32'd0);
  endtask

  initial begin
    reset = 1'b1; mw_clk = 1'b0; mw_data = 1'b0; mw_done = 1'b0;
    model_reset();
    tick(3);
    check_defaults("reset");
    reset = 1'b0;
    tick(2);

    frame(32'b10_011_101000, 11);            // master 40
    frame(32'b10_011_111111, 11);            // master 63 clamps to 40
    frame(32'b10_011_010100, 11);            // master 20
    frame(32'b10_011_101001, 11);            // master 41 clamps to 40
    frame(32'b01_101_010100, 11);            // wrong address
    frame(32'b10_011_010, 8);                // short frame
    frame(32'b10_001_001111, 11);            // bass 15 clamps to 12
    frame(32'b10_000_000011, 11);            // reserved mixer
    frame(32'b10_110_000000, 11);            // bad function
    frame(32'b10111_10_100_000101, 16);      // long frame, right 5
    frame(32'b10_000_000010, 11);            // mixer 2
    frame(32'b10_101_001100, 11);            // left 12
    frame(32'b10_101_011111, 11);            // left 31 clamps to 20
    frame(32'b10_010_001111, 11);            // treble 15 clamps to 12

    // Partial frame times out; the later mw_done lands in IDLE and is ignored.
    send_bits(32'b10011, 5, 1'b0);
    tick(TIMEOUT + 20);
    end_frame(1'b0, 1'b0);
    tick(10);
    frame(32'b10_010_000011, 11);            // treble 3

    // Last mw_clk rise coincident with mw_done rise.
    push_exp(32'b10_100_000111, 11);
    send_bits(32'b10_100_000111, 11, 1'b1);
    end_frame(1'b1, 1'b1);
    drain();

    // Back-to-back: first bit of the next frame arrives while decoding.
    push_exp(32'b10_011_000101, 11);
    push_exp(32'b10_101_000111, 11);
    send_bits(32'b10_011_000101, 11, 1'b0);
    tick(2);
    mw_done = 1'b1;
    tick(1);
    mw_data = 1'b1;
    mw_clk  = 1'b1;
    tick(2);
    mw_done = 1'b0;
    send_bits(32'b0_101_000111, 10, 1'b0);
    end_frame(1'b1, 1'b0);
    drain();

    // Reset mid-frame restores defaults and drops the partial frame.
    send_bits(32'b10_011_0, 6, 1'b0);
    reset = 1'b1;
    model_reset();
    tick(2);
    check_defaults("midreset");
    reset = 1'b0;
    end_frame(1'b0, 1'b0);
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/lmc_microwire_rx.md
Name: lmc_microwire_rx

Overview:
- Microwire responder modelling the STE LMC1992 volume/tone controller.
- Deserialises frames driven by the shifter's microwire master (mw_clk/mw_data/mw_done).
- Validates the 2-bit device address, decodes the 3-bit function and 6-bit data, and holds clamped volume/tone/mixer settings for the audio mixer downstream.

Parameters:
- DEV_ADDR, 2'b10, device address matched against frame bits [10:9].
- TIMEOUT, 512, clk32 cycles without an mw_clk rising edge before a partial frame is discarded.

Ports:
- clk32 input 1 system clock
- reset input 1 reset; synchronous, active-high
- mw_clk input 1 serial bit clock; mw_data sampled on its rising edge
- mw_data input 1 serial data, MSB first
- mw_done input 1 end-of-transfer; rising edge closes the frame
- master_vol output 6 master attenuation step 0..40 (40 = 0 dB, 2 dB/step)
- left_vol output 5 left attenuation step 0..20 (20 = 0 dB)
- right_vol output 5 right attenuation step 0..20
- bass output 4 bass step 0..12 (6 = flat)
- treble output 4 treble step 0..12 (6 = flat)
- mixer output 2 input mix select 0..2
- cmd_valid output 1 one-cycle pulse when a register is updated
- cmd_err output 1 one-cycle pulse when a frame is rejected

Behaviour:
- Edge detection: mw_clk and mw_done each pass through one clk32 register; a rise is current=1 AND previous=0. Inputs are synchronous to clk32, so no synchroniser is used.
- Reset values:
  - master_vol=40, left_vol=20, right_vol=20
  - bass=6, treble=6, mixer=1
  - cmd_valid=0, cmd_err=0
  - shift register=0, bit count=0, state=IDLE, timeout counter=0
- Reset mid-frame discards the frame with no pulse.
- FSM:
  - IDLE: an mw_clk rise shifts mw_data into the 11-bit shift register (shift left, LSB in), sets count=1, goes to SHIFT.
  - SHIFT:
    - each mw_clk rise shifts and increments count, saturating at 31;
    - timeout counter clears on each rise and otherwise increments;
    - timeout reaching TIMEOUT returns to IDLE, clears count, no pulse;
    - an mw_done rise goes to DECODE.
  - DECODE: lasts exactly one cycle, then IDLE with count cleared.
- Simultaneous mw_clk rise and mw_done rise in SHIFT: the bit is shifted first, and the frame includes it.
- mw_done rise in IDLE is ignored.
- Frame acceptance in DECODE, using the last 11 bits received (earlier bits drop out of the shift register). A frame is rejected with cmd_err when count<11 or bits[10:9]!=DEV_ADDR.
- Function = bits[8:6]; d = bits[5:0]:
  - 000 mixer = d[1:0]; d[1:0]=3 is reserved and rejected
  - 001 bass = min(d[3:0],12)
  - 010 treble = min(d[3:0],12)
  - 011 master_vol = min(d,40)
  - 100 right_vol = min(d[4:0],20)
  - 101 left_vol = min(d[4:0],20)
  - 110, 111 rejected
- Pulse timing:
  - accepted: target register updates and cmd_valid pulses on the clock edge leaving DECODE (two clk32 after the mw_done rise is seen);
  - rejected: cmd_err pulses instead and no register changes;
  - cmd_valid and cmd_err are never high together.
- Clamping uses unsigned compare on the stated field widths only.
- Back-to-back frames: an mw_clk rise during DECODE is not lost. It starts the next frame: shift register loads the new bit, count=1, next state SHIFT.

Decomposition:
- Shared package lmc_pkg:
  - function codes FN_MIXER..FN_LEFT
  - max constants 40/20/12
  - reset defaults
  - FSM state enum {IDLE, SHIFT, DECODE}
- One sub-module, lmc_frame_rx: edge detect, shift register, counter, timeout and FSM. It outputs the frame word, a frame_ok strobe and a frame_short strobe.
- The top level does decode, clamping and the setting registers.

Test Plan:
- Reset: assert reset 3 cycles -> master_vol=40, left_vol=20, right_vol=20, bass=6, treble=6, mixer=1, no pulses.
- Frame 10_011_101000 (master, d=40) then 10_011_111111 -> master_vol=40 both times, cmd_valid pulses twice. Frame d=0x14 -> master_vol=20.
- Frame 01_101_010100 (wrong address) -> cmd_err pulse, left_vol unchanged at 20. An 8-bit frame -> cmd_err.
- Frame 10_001_001111 -> bass=12. Frame 10_000_000011 -> cmd_err, mixer stays 1. Frame 10_110_000000 -> cmd_err.
- 16-bit frame whose last 11 bits are 10_100_000101 -> right_vol=5, cmd_valid.
- Timeout and collision cases:
  - 5 bits then TIMEOUT idle cycles, then a full frame 10_010_000011 -> treble=3 with no stale bits;
  - final mw_clk rise coincident with the mw_done rise -> frame decoded with that bit included.
